// File: rtl/pwm_6ch_core.sv
// 6-channel edge-aligned PWM counter/compare engine with period-boundary shadow updates.
module pwm_6ch_core #(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned PRESC_WIDTH = 8
) (
  input  logic                   s00_axi_aclk,
  input  logic                   s00_axi_aresetn,
  input  logic                   enable,
  input  logic [PRESC_WIDTH-1:0] prescale,
  input  logic [CNT_WIDTH-1:0]   period,
  input  logic [6*CNT_WIDTH-1:0] duty,
  input  logic [5:0]             polarity,
  input  logic                   update_req,
  output logic [5:0]             pwm_out,
  output logic                   period_tick,
  output logic                   update_done,
  output logic                   update_pending
);

  localparam int unsigned NCH = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                 state_q,      state_d;
  logic [PRESC_WIDTH-1:0] presc_q,      presc_d;
  logic [CNT_WIDTH-1:0]   cnt_q,        cnt_d;
  logic [CNT_WIDTH-1:0]   period_s_q,   period_s_d;
  logic [PRESC_WIDTH-1:0] prescale_s_q, prescale_s_d;
  logic [NCH*CNT_WIDTH-1:0] duty_s_q,   duty_s_d;
  logic [NCH-1:0]         polarity_s_q, polarity_s_d;
  logic                   pending_q,    pending_d;
  logic [NCH-1:0]         pwm_q,        pwm_d;
  logic                   tick_q,       tick_d;
  logic                   done_q,       done_d;

  logic                   presc_tick_c;
  logic                   wrap_c;
  logic                   load_c;
  logic [NCH-1:0]         cmp_c;

  // Prescaler terminal count and counter wrap detection against the shadow values
  always_comb begin
    presc_tick_c = (presc_q == prescale_s_q);
    wrap_c       = presc_tick_c && (cnt_q == period_s_q);
  end

  // Per-channel compare, polarity applied before the output register
  always_comb begin
    cmp_c = '0;
    for (int i = 0; i < NCH; i++) begin
      cmp_c[i] = (cnt_q < duty_s_q[i*CNT_WIDTH +: CNT_WIDTH]) ^ polarity_s_q[i];
    end
  end

  // Next-state, counter, handshake and shadow-load decisions
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    pwm_d     = pwm_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;
    load_c    = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d   = '0;
        cnt_d     = '0;
        pending_d = 1'b0;
        pwm_d     = polarity_s_q;
        if (update_req) begin
          load_c = 1'b1;
          done_d = 1'b1;
        end
        if (enable) begin
          state_d = RUN;
          load_c  = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          // Abort immediately: no period completion, pending update is dropped
          state_d   = IDLE;
          presc_d   = '0;
          cnt_d     = '0;
          pending_d = 1'b0;
          pwm_d     = polarity_s_q;
        end else begin
          pwm_d   = cmp_c;
          presc_d = presc_tick_c ? '0 : presc_q + PRESC_WIDTH'(1);
          if (presc_tick_c) begin
            cnt_d = wrap_c ? '0 : cnt_q + CNT_WIDTH'(1);
          end
          tick_d = wrap_c;
          if (wrap_c && (pending_q || update_req)) begin
            load_c    = 1'b1;
            pending_d = 1'b0;
            done_d    = 1'b1;
          end else if (update_req) begin
            pending_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    period_s_d   = load_c ? period   : period_s_q;
    prescale_s_d = load_c ? prescale : prescale_s_q;
    duty_s_d     = load_c ? duty     : duty_s_q;
    polarity_s_d = load_c ? polarity : polarity_s_q;
  end

  // State, counters, shadows and registered outputs
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      cnt_q        <= '0;
      period_s_q   <= '0;
      prescale_s_q <= '0;
      duty_s_q     <= '0;
      polarity_s_q <= '0;
      pending_q    <= 1'b0;
      pwm_q        <= '0;
      tick_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      cnt_q        <= cnt_d;
      period_s_q   <= period_s_d;
      prescale_s_q <= prescale_s_d;
      duty_s_q     <= duty_s_d;
      polarity_s_q <= polarity_s_d;
      pending_q    <= pending_d;
      pwm_q        <= pwm_d;
      tick_q       <= tick_d;
      done_q       <= done_d;
    end
  end

  assign pwm_out        = pwm_q;
  assign period_tick    = tick_q;
  assign update_done    = done_q;
  assign update_pending = pending_q;

endmodule

// File: doc/pwm_6ch_core.md
Name: pwm_6ch_core

Overview:
- Counter/compare engine sitting directly downstream of the AXI4-Lite register slave in the 6-channel PWM IP.
- Consumes the raw register-file values (enable, prescale, period, six duty words, polarity) and produces six edge-aligned PWM outputs.
- Uses shadow registers so that software updates take effect glitch-free at a period boundary.

Parameters:
- CNT_WIDTH, 16, width of the period counter, the period word and each duty word
- PRESC_WIDTH, 8, width of the clock prescaler divisor

Ports:
- s00_axi_aclk  in  1  clock, shared with the register slave
- s00_axi_aresetn  in  1  asynchronous active-low reset
- enable  in  1  run control, level-sensitive
- prescale  in  PRESC_WIDTH  a count tick occurs every prescale+1 clocks
- period  in  CNT_WIDTH  terminal count; PWM period is (period+1) ticks
- duty  in  6*CNT_WIDTH  packed compare values; channel i occupies [i*CNT_WIDTH +: CNT_WIDTH]
- polarity  in  6  per-channel output inversion
- update_req  in  1  single-cycle pulse from the register slave on any config write
- pwm_out  out  6  PWM outputs, registered
- period_tick  out  1  one-cycle pulse on counter wrap
- update_done  out  1  one-cycle pulse when the shadow registers are loaded
- update_pending  out  1  high while an update is waiting for a wrap

Behaviour:
- Reset state (async assert, sync release): all internal registers are 0, and pwm_out, period_tick, update_done and update_pending are 0.
- Shadow registers hold period_s, duty_s[6], polarity_s and prescale_s. The counter and compare logic use only the shadow values.
- State machine IDLE / RUN:
  - IDLE:
    - Counter and prescaler are held at 0.
    - pwm_out = polarity_s, registered.
    - update_req loads the shadows on the next edge; update_done pulses and update_pending stays 0.
  - IDLE -> RUN when enable=1:
    - Shadows are loaded from the inputs on that edge.
    - cnt = 0 and the prescaler is cleared.
    - Any pending flag is cleared.
  - RUN -> IDLE when enable=0:
    - Takes effect on the next edge; no completion of the current period.
    - pending is cleared with no update_done.
- Prescaler (RUN): counts 0..prescale_s and asserts tick on the cycle where it equals prescale_s, then wraps to 0. prescale_s=0 gives a tick every clock.
- Counter (RUN):
  - On tick: if cnt == period_s then cnt <= 0 and period_tick pulses on the following cycle; otherwise cnt <= cnt+1.
  - With no tick, cnt holds.
- Compare: pwm_out[i] <= (cnt < duty_s[i]) ^ polarity_s[i], registered (1-cycle latency after cnt).
  - duty=0 gives constant inactive level.
  - duty >= period+1 gives constant active level, with no glitch at wrap.
  - period=0: cnt stays 0 and wraps every tick; outputs are 100% if duty>0, else 0%.
- Update handshake (RUN):
  - update_req sets update_pending.
  - On the wrap edge (tick and cnt==period_s) with pending=1: shadows load from the current inputs, pending clears, and update_done pulses the next cycle.
  - The new values govern the period starting at cnt=0.
- update_req coincident with a wrap edge: the load happens on that same wrap and pending is never visibly set. The inputs are sampled that cycle.
- Repeated update_req while pending: pending stays 1 and only one load occurs, using the input values at the wrap.
- Comparisons are unsigned, with no arithmetic overflow. cnt never exceeds period_s, so the +1 never wraps past 2^CNT_WIDTH-1.
- Reset asserted mid-period: outputs drop to 0 asynchronously. After release the block is in IDLE with zero shadows.

Test Plan:
- Reset then enable=1, prescale=0, period=9, duty0=3, others 0, polarity=0 -> pwm_out[0] is high 3 clocks and low 7 of every 10; period_tick pulses every 10 clocks; pwm_out[5:1]=0.
- prescale=4, period=3, duty1=2 -> tick every 5 clocks; pwm_out[1] high 10 clocks of every 20; period_tick spacing is 20.
- Running at duty0=3; write duty0=7 with an update_req pulse mid-period (cnt=5) -> update_pending=1 until wrap; remainder of that period is unchanged; update_done pulses once; next period is high for 7 clocks.
- duty2=0, duty3=10 with period=9, polarity=6'b000100 -> pwm_out[2] constant 1 and pwm_out[3] constant 1, with no glitch across wraps.
- update_req on the exact wrap cycle -> new duty applies in the immediately following period; update_pending never seen high.
- enable dropped at cnt=4 with pending=1 -> next cycle cnt=0, pwm_out=polarity_s, pending=0 with no update_done. Then assert reset mid-run -> all outputs 0 immediately.
